// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM RW0 requester-side controller.
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        S_INIT,
        S_IDLE
    } state_e;

    localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/sram_rsp_buf.sv
// Two-entry read-response FIFO; data arriving while empty is presented in the same cycle.
module sram_rsp_buf
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic              rdPtr_q, rdPtr_d;
    logic              wrPtr_q, wrPtr_d;
    logic [1:0]        occ_q, occ_d;
    logic              empty;
    logic              storePush;
    logic              storePop;

    // A bypassed word that is consumed immediately never touches storage.
    always_comb begin
        empty     = (occ_q == 2'd0);
        storePush = push_i && !(empty && ready_i);
        storePop  = !empty && ready_i;
        rdPtr_d   = storePop  ? rdPtr_q + 1'b1 : rdPtr_q;
        wrPtr_d   = storePush ? wrPtr_q + 1'b1 : wrPtr_q;
        occ_d     = occ_q;
        if (storePush && !storePop) begin
            occ_d = occ_q + 2'd1;
        end else if (!storePush && storePop) begin
            occ_d = occ_q - 2'd1;
        end
        valid_o = push_i || !empty;
        data_o  = '0;
        if (!empty) begin
            data_o = mem_q[rdPtr_q];
        end else if (push_i) begin
            data_o = data_i;
        end
    end

    assign occ_o = occ_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            if (storePush) begin
                mem_q[wrPtr_q] <= data_i;
            end
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: rtl/sram_rw0_ctrl.sv
// Serialises read/write request channels onto a single-port SRAM RW0 port.
// Define SRAM_CTRL_INIT_EN to sweep INIT_VAL into every entry after reset release.
module sram_rw0_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [DATA_W-1:0] wr_req_mask,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e            state_q;
    logic              initDone_q;
    logic              inflight_q;
    logic              sweepActive_q;
    logic [ADDR_W-1:0] initCnt_q;
    logic              isIdle;
    logic              rdSlotFree;
    logic              rdIssue;
    logic [1:0]        rspOcc;

    // Writes win the port; a read only issues when its response has a guaranteed buffer slot.
    always_comb begin
        isIdle       = (state_q == S_IDLE);
        rdSlotFree   = ({1'b0, rspOcc} + {2'b00, inflight_q}) < 3'd2;
        wr_req_ready = isIdle;
        rd_req_ready = isIdle && !wr_req_valid && rdSlotFree;
        rdIssue      = rd_req_valid && rd_req_ready;
        sram_en      = 1'b0;
        sram_wmode   = 1'b0;
        sram_addr    = '0;
        sram_wmask   = '0;
        sram_wdata   = '0;
        if (isIdle && wr_req_valid) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_req_addr;
            sram_wmask = wr_req_mask;
            sram_wdata = wr_req_data;
        end else if (rdIssue) begin
            sram_en   = 1'b1;
            sram_addr = rd_req_addr;
        end else if (sweepActive_q) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = initCnt_q;
            sram_wmask = '1;
            sram_wdata = INIT_VAL;
        end
    end

    assign init_done = initDone_q;

    // The sweep flag is held low through reset so no write escapes before release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            initDone_q    <= 1'b0;
            inflight_q    <= 1'b0;
            sweepActive_q <= 1'b0;
            initCnt_q     <= '0;
        end else begin
            inflight_q <= rdIssue;
            case (state_q)
                S_INIT: begin
`ifdef SRAM_CTRL_INIT_EN
                    if (!sweepActive_q) begin
                        sweepActive_q <= 1'b1;
                    end else if (initCnt_q == '1) begin
                        sweepActive_q <= 1'b0;
                        state_q       <= S_IDLE;
                        initDone_q    <= 1'b1;
                    end else begin
                        initCnt_q <= initCnt_q + 1'b1;
                    end
`else
                    state_q    <= S_IDLE;
                    initDone_q <= 1'b1;
`endif
                end
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    sram_rsp_buf #(
        .DATA_W(DATA_W)
    ) u_rsp_buf (
        .clock  (clock),
        .reset  (reset),
        .push_i (inflight_q),
        .data_i (sram_rdata),
        .valid_o(rd_resp_valid),
        .ready_i(rd_resp_ready),
        .data_o (rd_resp_data),
        .occ_o  (rspOcc)
    );

endmodule
